// File: rtl/mic1_run_ctrl.sv
// mic1_run_ctrl -- run-control front end for the MIC-1 core.
//
// Debounces the four board push buttons and runs an IDLE/RUN/STEP/HALT state
// machine. It drives the core clock enable, a stretched synchronous core
// reset, and a wrapping executed-cycle counter for the LEDs.
//
// Ports:
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   btn[3:0]  in   raw active-high buttons: 0=RUN 1=STOP 2=STEP 3=CORE_RESET
//   clk_en    out  MIC-1 clock enable (one core cycle per high clk cycle)
//   core_rst  out  synchronous active-high reset to the core
//   led_run   out  high in RUN
//   led_step  out  high in STEP or HALT
//   led_cnt   out  executed-cycle counter, wraps silently
//   state     out  IDLE=0 RUN=1 STEP=2 HALT=3
//
// Build option: define MIC1_BTN_AUTOREPEAT_EN to enable STEP auto-repeat
// while the button stays held in HALT. The REPEAT_CYCLES parameter only
// exists in that build, so the default build carries no dead parameter.
module mic1_run_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 100000,
  parameter int STEP_LEN      = 1,
  parameter int RST_LEN       = 4,
  parameter int CNT_W         = 4
`ifdef MIC1_BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 5000000
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       btn,
  output logic             clk_en,
  output logic             core_rst,
  output logic             led_run,
  output logic             led_step,
  output logic [CNT_W-1:0] led_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int SW  = $clog2(STEP_LEN + 1);
  localparam int RW  = $clog2(RST_LEN + 1);

  logic [3:0] pls;  // one-cycle registered press pulses

  // Per-button synchroniser + debouncer + press-pulse generator.
  for (genvar g = 0; g < 4; g++) begin : g_db
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DBW-1:0]         cnt_q;
    logic                   lvl_q, lvl_dly_q, pls_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_q    <= '0;
        cnt_q     <= '0;
        lvl_q     <= 1'b0;
        lvl_dly_q <= 1'b0;
        pls_q     <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn[g]};
        // Count consecutive mismatches; any agreement restarts the count.
        if (sync_q[SYNC_STAGES-1] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
          cnt_q <= '0;
          lvl_q <= ~lvl_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        lvl_dly_q <= lvl_q;
        pls_q     <= lvl_q & ~lvl_dly_q;
      end
    end

    assign pls[g] = pls_q;
  end

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [RW-1:0]    rst_q, rst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef MIC1_BTN_AUTOREPEAT_EN
  localparam int RPW = $clog2(REPEAT_CYCLES + 1);
  logic [RPW-1:0] rep_q, rep_d;
  logic           step_held;
  assign step_held = g_db[2].lvl_q;
`endif

  assign clk_en   = (state_q == S_RUN) || (state_q == S_STEP);
  assign led_run  = (state_q == S_RUN);
  assign led_step = (state_q == S_STEP) || (state_q == S_HALT);
  assign core_rst = (rst_q != '0);
  assign led_cnt  = cnt_q;
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rst_d   = rst_q;
    cnt_d   = cnt_q;
`ifdef MIC1_BTN_AUTOREPEAT_EN
    rep_d   = '0;
`endif
    if (rst_q != '0) rst_d = rst_q - 1'b1;
    if (clk_en)      cnt_d = cnt_q + 1'b1;

    if (pls[3]) begin
      state_d = S_IDLE;
      step_d  = '0;
      rst_d   = RW'(RST_LEN);
      cnt_d   = '0;
    end else if (rst_q == '0) begin
      // Presses are ignored while the core reset is stretching so that
      // clk_en can never overlap core_rst.
      case (state_q)
        S_IDLE, S_HALT: begin
          if (pls[2] && !pls[1]) begin
            state_d = S_STEP;
            step_d  = '0;
          end else if (pls[0] && !pls[1]) begin
            state_d = S_RUN;
          end
`ifdef MIC1_BTN_AUTOREPEAT_EN
          // A held STEP in HALT re-arms a step every REPEAT_CYCLES cycles;
          // a release or any press leaves rep_d at its cleared default.
          else if (state_q == S_HALT && step_held && pls == 4'b0000) begin
            if (rep_q == RPW'(REPEAT_CYCLES - 1)) begin
              state_d = S_STEP;
              step_d  = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
`endif
        end
        S_RUN: begin
          if (pls[1] || pls[2]) state_d = S_HALT;
        end
        default: begin  // S_STEP
          if (pls[1] || step_q == SW'(STEP_LEN - 1)) state_d = S_HALT;
          else                                        step_d  = step_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      rst_q   <= '0;
      cnt_q   <= '0;
`ifdef MIC1_BTN_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rst_q   <= rst_d;
      cnt_q   <= cnt_d;
`ifdef MIC1_BTN_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

endmodule
